boot_loader: RTL

//  Upstream stage of the processor/SRAM top: streams a program image, from a byte source

---
 rtl/boot_loader_pkg.sv | 18 +
 rtl/boot_loader_byte_packer.sv | 38 +++
 rtl/boot_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Purpose: shared constants and FSM state encoding for the boot loader slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package boot_loader_pkg;

  // Word-address width of the SRAM data port the loader drives.
  localparam int MEM_ADDR_WIDTH = 10;

  // Loader FSM states.
  typedef enum logic [2:0] {
    LD_HDR  = 3'd0,   // collecting the 4-byte big-endian word count
    LD_DATA = 3'd1,   // collecting payload words and writing them out
    LD_CSUM = 3'd2,   // waiting for the trailing checksum byte
    LD_DONE = 3'd3,   // image good, processor released (terminal)
    LD_ERR  = 3'd4    // size overflow or bad checksum (terminal)
  } ld_state_t;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Purpose: packs a byte stream into big-endian 32-bit words, flags the 4th byte.
// Latency: word is combinational on the 4th byte (includes the byte being shifted in).
// Backpressure: none; shifts exactly when shift=1.
//
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   shift       accept data this cycle
//   data        incoming byte
//   word        {previous three bytes, data}; valid as a full word when word_done=1
//   word_done   1 when the byte being accepted completes a word
module boot_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);

  // Only three bytes need storing: the fourth is taken straight from data
  // in the completing cycle, so the word is available without an extra stage.
  logic [23:0] word_sr;
  logic [1:0]  byte_cnt;

  assign word      = {word_sr, data};
  assign word_done = shift && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_sr  <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      word_sr  <= {word_sr[15:0], data};
      byte_cnt <= byte_cnt + 2'd1;   // wraps 3 -> 0 at the end of each word
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Purpose: streams a length-prefixed, checksummed program image into SRAM, then releases the CPU.
// Latency: SRAM write issued 1 cycle after the 4th byte of a word; cpu_run rises 1 cycle after the checksum byte.
// Backpressure: in_ready=1 in HDR/DATA/CSUM (never drops bytes), 0 once DONE or ERR.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset (0 = reset)
//   in_data/valid/ready  byte stream; transfer = in_valid & in_ready
//   mem_addr/wdata/bwe   SRAM write port; bwe=4'hF for one cycle per word
//   cpu_run              1 = processor released
//   load_err             sticky error: oversize image or checksum mismatch
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_bwe,
  output logic              cpu_run,
  output logic              load_err
);

  // Largest legal word count: exactly fills the address space.
  localparam logic [32:0] MAX_N = 33'd1 << ADDR_W;

  ld_state_t         state, next_state;
  logic              xfer;
  logic              pk_shift;
  logic [31:0]       pk_word;
  logic              word_done;
  logic [7:0]        csum;
  logic [7:0]        csum_next;
  logic [ADDR_W:0]   words_left;   // one bit wider so N = 2**ADDR_W fits
  logic [ADDR_W-1:0] word_addr;
  logic              hdr_too_big;
  logic              hdr_zero;
  logic              last_word;

  assign xfer      = in_valid && in_ready;
  // The packer is shared by header and payload; the checksum byte bypasses it.
  assign pk_shift  = xfer && (state == LD_HDR || state == LD_DATA);
  assign csum_next = csum + in_data;

  // Header decode uses the full 32-bit count so huge values are caught,
  // not truncated into something that looks legal.
  assign hdr_too_big = {1'b0, pk_word} > MAX_N;
  assign hdr_zero    = (pk_word == 32'd0);
  assign last_word   = (words_left == (ADDR_W+1)'(1));

  boot_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift     (pk_shift),
    .data      (in_data),
    .word      (pk_word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LD_HDR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      LD_HDR: begin
        if (word_done) begin
          if (hdr_too_big) begin
            next_state = LD_ERR;
          end else if (hdr_zero) begin
            next_state = LD_CSUM;
          end else begin
            next_state = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (word_done && last_word) begin
          next_state = LD_CSUM;
        end
      end
      LD_CSUM: begin
        if (xfer) begin
          // Including the checksum byte, the whole image must sum to zero.
          next_state = (csum_next == 8'h00) ? LD_DONE : LD_ERR;
        end
      end
      LD_DONE: next_state = LD_DONE;
      LD_ERR:  next_state = LD_ERR;
      default: next_state = LD_ERR;
    endcase
  end

  // Datapath: counters, checksum, write register and status flags.
  // Status outputs are registered from next_state so they change on the same
  // edge as the state, and in_ready is held low while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready   <= 1'b0;
      cpu_run    <= 1'b0;
      load_err   <= 1'b0;
      csum       <= '0;
      words_left <= '0;
      word_addr  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_bwe    <= '0;
    end else begin
      in_ready <= (next_state == LD_HDR) || (next_state == LD_DATA) ||
                  (next_state == LD_CSUM);
      cpu_run  <= (next_state == LD_DONE);
      load_err <= (next_state == LD_ERR);
      mem_bwe  <= 4'h0;

      if (xfer) begin
        csum <= csum_next;
      end

      if (state == LD_HDR && word_done) begin
        words_left <= pk_word[ADDR_W:0];
      end

      // Address and data are only updated on a write so they hold between writes.
      if (state == LD_DATA && word_done) begin
        mem_bwe    <= 4'hF;
        mem_addr   <= word_addr;
        mem_wdata  <= pk_word;
        word_addr  <= word_addr + ADDR_W'(1);
        words_left <= words_left - (ADDR_W+1)'(1);
      end
    end
  end

endmodule
